rv32_arbiter: RTL and testbench
===============================

RV32_ARBITER -- requirements
Module: rv32_arbiter

Interface
REQ-001 Param TIMEOUT, default 64, max cycles a granted access waits for s_ready; 0 disables the timeout.
REQ-002 Param ERR_RDATA, default 32'h0000_0000, rdata returned to the master on a timed-out access.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 m0_valid/m1_valid  input  1  master request, held until matching ready.
REQ-006 m0_ready/m1_ready  output  1  one-cycle completion pulse to master.
REQ-007 m0_addr/m1_addr, m0_wdata/m1_wdata  input  32  per-master address, write data.
REQ-008 m0_wstrb/m1_wstrb  input  4  byte strobes; 0 = read.
REQ-009 m0_rdata/m1_rdata  output  32  read data, valid with matching ready.
REQ-010 s_valid  output  1  request to the downstream rv32 slave (e.g. rv32_bram).
REQ-011 s_ready  input  1  slave completion pulse.
REQ-012 s_addr/s_wdata  output  32; s_wstrb  output  4; s_rdata  input  32.
REQ-013 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-014 timeout_err  output  1  one-cycle pulse on a timed-out access.

Function
REQ-015 Two states shall exist: IDLE and BUSY; the owner is held in a registered index.
REQ-016 IDLE, no mX_valid -> stay IDLE.
REQ-016a IDLE, any mX_valid -> BUSY next cycle with owner = winner.
REQ-017 Arbitration shall be round-robin: one requester wins; if both, the master not served last wins.
REQ-018 In BUSY, s_valid/s_addr/s_wdata/s_wstrb shall combinationally equal the owner's signals; non-owner inputs are ignored.
REQ-019 In IDLE, s_valid shall be 0 and s_addr/s_wdata/s_wstrb shall be 0.
REQ-020 In BUSY, owner's mX_ready = s_ready combinationally; owner's mX_rdata = s_rdata; non-owner ready = 0.
REQ-021 BUSY with s_ready=1 -> IDLE next cycle; last-served <= owner.
REQ-022 Arbitration latency: request seen in IDLE reaches the slave one cycle later; no back-to-back grant without an intervening IDLE cycle.
REQ-023 A wait counter shall clear on entry to BUSY and increment each BUSY cycle without s_ready, saturating at TIMEOUT.
REQ-024 When TIMEOUT!=0, counter==TIMEOUT and s_ready=0:
  - owner mX_ready=1, mX_rdata=ERR_RDATA
  - s_valid=0
  - timeout_err=1
  - -> IDLE next cycle
REQ-025 s_ready and timeout in the same cycle: s_ready wins; slave data returned, no timeout_err.
REQ-026 Owner dropping valid before ready is a protocol violation; grant shall still be held until s_ready or timeout.
REQ-027 Requests arriving while BUSY shall wait in the masters' held valid; none shall be lost or reordered per master.
REQ-027a Non-owner mX_rdata shall read 0.

Reset
REQ-028 rst=1 shall immediately force IDLE, counter=0, last-served=m1 (so m0 wins first tie), grant=0, timeout_err=0.
REQ-029 Combinational outputs shall follow REQ-019/020 during reset.
REQ-030 Reset mid-BUSY shall abandon the access with no ready to either master.

Structure
REQ-031 Shared rv32 package shall hold: bus widths (ADDR 32, DATA 32, STRB 4), arbiter state encodings, ERR_RDATA default.
REQ-032 One sub-module rv32_rr_pick (2 requests + last-served -> one-hot winner), combinational, reusable for wider arbiters.

Verification
REQ-033 m0 read addr 0x10, slave ready after 2 cycles with rdata 0xCAFEF00D -> m0_ready single pulse, m0_rdata=0xCAFEF00D, m1_ready=0 throughout.
REQ-034 Both valid in first post-reset IDLE -> m0 granted first, then m1; s_addr sequence m0_addr, m1_addr.
REQ-035 m1 write 0x12345678 wstrb 4'b0011 to rv32_bram at 0x8 -> BRAM word 2 low half updated, upper bytes unchanged, m1_ready once.
REQ-036 TIMEOUT=4, slave never ready -> 4 BUSY cycles, then m0_ready=1, rdata=ERR_RDATA, timeout_err one pulse, back to IDLE.
REQ-037 s_ready coincident with the timeout cycle -> slave rdata returned, timeout_err=0.
REQ-038 rst asserted mid-BUSY -> s_valid=0 same cycle, grant=0, no mX_ready; first tie after release goes to m0.

Source files
------------

// File: rtl/rv32_arbiter_pkg.sv
// Shared rv32 bus definitions for the
// two-master arbiter and its helpers.
package rv32_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF =
    32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } rv32_req_t;

endpackage

// File: rtl/rv32_arbiter_rr_pick.sv
// Round-robin winner select: scans from
// the slot after last-served, first hit wins.
module rv32_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_arbiter.sv
// Two-master rv32 bus arbiter with
// round-robin grant and access timeout.
module rv32_arbiter
  import rv32_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA =
    ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t  st, st_nx;
  rv32_req_t   req [2];
  rv32_req_t   sel;
  logic [1:0]  reqv, win;
  logic        own, last, pick;
  logic        busy, to_hit, to_fire, done;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rd;

  assign req[0] =
    {m0_valid, m0_addr, m0_wdata, m0_wstrb};
  assign req[1] =
    {m1_valid, m1_addr, m1_wdata, m1_wstrb};
  assign reqv = {m1_valid, m0_valid};

  rv32_rr_pick #(.N(2)) u_pick (
    .req  (reqv),
    .last (last),
    .win  (win)
  );

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      win[0]:  pick = 1'b0;
      win[1]:  pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  assign busy   = (st == ST_BUSY);
  assign to_hit = (TIMEOUT != 0) &&
                  (cnt == CW'(TIMEOUT));
  assign to_fire = busy && to_hit && !s_ready;
  assign done    = busy && (s_ready || to_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= ST_IDLE;
      own  <= 1'b0;
      last <= 1'b1;
      cnt  <= '0;
    end else begin
      st <= st_nx;
      if (!busy) begin
        cnt <= '0;
        if (|reqv) own <= pick;
      end else begin
        if (done) last <= own;
        if (!s_ready && !to_hit)
          cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE: if (|reqv) st_nx = ST_BUSY;
      ST_BUSY: if (done)  st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  // Timeout cycle completes to the owner
  // and withdraws the slave request.
  always_comb begin
    sel         = req[own];
    rd          = s_ready ? s_rdata : ERR_RDATA;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    grant       = 2'b00;
    timeout_err = to_fire;
    if (busy) begin
      s_valid  = sel.valid && !to_fire;
      s_addr   = sel.addr;
      s_wdata  = sel.wdata;
      s_wstrb  = sel.wstrb;
      m0_ready = done && !own;
      m1_ready = done && own;
      m0_rdata = own ? '0 : rd;
      m1_rdata = own ? rd : '0;
      grant    = own ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_rv32_arbiter.sv
// Directed bench for rv32_arbiter with a
// small byte-strobed memory as the slave.
module tb_rv32_arbiter;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [31:0] bram [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_arbiter #(
    .TIMEOUT   (4),
    .ERR_RDATA (ERR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_valid    (m0_valid),
    .m0_ready    (m0_ready),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_ready    (m1_ready),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        bram[i] <= 32'hAABB_CCDD;
    end else if (s_valid && s_ready) begin
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b])
          bram[s_addr[5:2]][b*8 +: 8] <=
            s_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m1_addr = 0;
    m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_svalid", s_valid, 0);
    chk("rst_toerr", timeout_err, 0);
    m0_valid = 1; m0_addr = 32'h44;
    #1;
    chk("rst_svalid_req", s_valid, 0);
    chk("rst_saddr_req", s_addr, 0);
    chk("rst_m0ready", m0_ready, 0);
    m0_valid = 0;
    step(); step();
    rst = 1'b0;

    // m0 read, slave ready on third BUSY cycle
    m0_valid = 1; m0_addr = 32'h10;
    #1;
    chk("a_idle_svalid", s_valid, 0);
    chk("a_idle_grant", grant, 2'b00);
    step(); #1;
    chk("a_grant", grant, 2'b01);
    chk("a_svalid", s_valid, 1);
    chk("a_saddr", s_addr, 32'h10);
    chk("a_m0ready_wait", m0_ready, 0);
    step(); #1;
    chk("a_m0ready_wait2", m0_ready, 0);
    step();
    s_ready = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    chk("a_m0ready", m0_ready, 1);
    chk("a_m0rdata", m0_rdata, 32'hCAFE_F00D);
    chk("a_m1ready", m1_ready, 0);
    step();
    m0_valid = 0; s_ready = 0;
    #1;
    chk("a_done_grant", grant, 2'b00);
    chk("a_done_m0ready", m0_ready, 0);
    chk("a_done_svalid", s_valid, 0);

    // fresh reset then a tie
    rst = 1; step(); rst = 0;
    m0_valid = 1; m0_addr = 32'h100;
    m1_valid = 1; m1_addr = 32'h200;
    step(); #1;
    chk("b_grant0", grant, 2'b01);
    chk("b_saddr0", s_addr, 32'h100);
    s_ready = 1; s_rdata = 32'h1111_1111;
    #1;
    chk("b_m0ready", m0_ready, 1);
    chk("b_m1ready0", m1_ready, 0);
    chk("b_m1rdata0", m1_rdata, 0);
    step();
    m0_valid = 0; s_ready = 0;
    #1;
    chk("b_gap_grant", grant, 2'b00);
    chk("b_gap_svalid", s_valid, 0);
    step(); #1;
    chk("b_grant1", grant, 2'b10);
    chk("b_saddr1", s_addr, 32'h200);
    s_ready = 1; s_rdata = 32'h2222_2222;
    #1;
    chk("b_m1ready", m1_ready, 1);
    chk("b_m1rdata", m1_rdata, 32'h2222_2222);
    chk("b_m0rdata", m0_rdata, 0);
    chk("b_m0ready", m0_ready, 0);
    step();
    m1_valid = 0; s_ready = 0;

    // m1 half-word write into memory word 2
    m1_valid = 1; m1_addr = 32'h8;
    m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    step(); #1;
    chk("c_grant", grant, 2'b10);
    chk("c_swstrb", s_wstrb, 4'b0011);
    chk("c_swdata", s_wdata, 32'h1234_5678);
    s_ready = 1;
    #1;
    chk("c_m1ready", m1_ready, 1);
    step();
    m1_valid = 0; m1_wstrb = 0; s_ready = 0;
    #1;
    chk("c_bram2", bram[2], 32'hAABB_5678);
    chk("c_bram3", bram[3], 32'hAABB_CCDD);
    chk("c_m1ready_off", m1_ready, 0);

    // slave never answers: timeout
    m0_valid = 1; m0_addr = 32'h20;
    step(); #1;
    chk("d_grant", grant, 2'b01);
    chk("d_svalid", s_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("d_wait_svalid", s_valid, 1);
      chk("d_wait_ready", m0_ready, 0);
      chk("d_wait_toerr", timeout_err, 0);
    end
    step(); #1;
    chk("d_to_ready", m0_ready, 1);
    chk("d_to_rdata", m0_rdata, ERR);
    chk("d_to_err", timeout_err, 1);
    chk("d_to_svalid", s_valid, 0);
    step();
    m0_valid = 0;
    #1;
    chk("d_idle_grant", grant, 2'b00);
    chk("d_idle_toerr", timeout_err, 0);

    // s_ready exactly on the timeout cycle
    m1_valid = 1; m1_addr = 32'h30;
    step(); #1;
    chk("e_grant", grant, 2'b10);
    for (int i = 0; i < 3; i++) step();
    step();
    s_ready = 1; s_rdata = 32'h5555_AAAA;
    #1;
    chk("e_m1ready", m1_ready, 1);
    chk("e_m1rdata", m1_rdata, 32'h5555_AAAA);
    chk("e_toerr", timeout_err, 0);
    step();
    m1_valid = 0; s_ready = 0;
    #1;
    chk("e_idle_grant", grant, 2'b00);

    // m0 served, then reset while m1 is busy
    m0_valid = 1; m0_addr = 32'h40;
    step();
    s_ready = 1;
    #1;
    chk("f_m0ready", m0_ready, 1);
    step();
    m0_valid = 0; s_ready = 0;
    m1_valid = 1; m1_addr = 32'h50;
    step(); #1;
    chk("f_grant_m1", grant, 2'b10);
    rst = 1; s_ready = 1;
    #1;
    chk("f_rst_svalid", s_valid, 0);
    chk("f_rst_grant", grant, 2'b00);
    chk("f_rst_m1ready", m1_ready, 0);
    chk("f_rst_m0ready", m0_ready, 0);
    step(); #1;
    chk("f_rst_hold_m1ready", m1_ready, 0);
    rst = 0; s_ready = 0;
    m0_valid = 1; m0_addr = 32'h60;
    #1;
    chk("f_rel_grant", grant, 2'b00);
    step(); #1;
    chk("f_tie_grant", grant, 2'b01);
    chk("f_tie_saddr", s_addr, 32'h60);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
